// File: rtl/neuron_layer_sequencer_pkg.sv
// Shared types and constants for the neuron layer sequencer and its MAC datapath.
package neuron_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        MAC  = 2'd1,
        EMIT = 2'd2
    } state_t;

    // Step activation levels in Q8.8: 1.0 and 0.0.
    localparam logic [15:0] ACT_ONE  = 16'h0100;
    localparam logic [15:0] ACT_ZERO = 16'h0000;

    // Accumulator width at the default 16-bit data width.
    localparam int ACC_W = 32;

    function automatic int acc_w(input int data_w);
        return 2 * data_w;
    endfunction

endpackage

// File: rtl/neuron_layer_sequencer_if.sv
// Bus bundle between the input-vector source / next layer (master) and the sequencer (slave).
interface neuron_layer_sequencer_if #(
    parameter int DATA_W    = 16,
    parameter int N_INPUTS  = 8,
    parameter int N_NEURONS = 4
);
    localparam int ADDR_W = $clog2(N_INPUTS * N_NEURONS);
    localparam int IDX_W  = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

    // Both streams transfer on a rising clock edge where valid && ready; the sender
    // holds data stable while valid is high and ready is low, ready never waits on valid.
    logic                     io_wr_en;
    logic [ADDR_W-1:0]        io_wr_addr;
    logic signed [DATA_W-1:0] io_wr_data;
    logic                     io_in_valid;
    logic                     io_in_ready;
    logic signed [DATA_W-1:0] io_in_data;
    logic                     io_out_valid;
    logic                     io_out_ready;
    logic [DATA_W-1:0]        io_out_data;
    logic [IDX_W-1:0]         io_out_idx;
    logic                     io_busy;

    modport master (
        output io_wr_en, io_wr_addr, io_wr_data, io_in_valid, io_in_data, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_data, io_out_idx, io_busy
    );

    modport slave (
        input  io_wr_en, io_wr_addr, io_wr_data, io_in_valid, io_in_data, io_out_ready,
        output io_in_ready, io_out_valid, io_out_data, io_out_idx, io_busy
    );

endinterface

// File: rtl/neuron_layer_sequencer_mac2.sv
// Two-term signed multiply-add; the sum wraps modulo 2^(2*DATA_W).
module neuron_mac2
    import neuron_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic signed [DATA_W-1:0]        x0,
    input  logic signed [DATA_W-1:0]        w0,
    input  logic signed [DATA_W-1:0]        x1,
    input  logic signed [DATA_W-1:0]        w1,
    output logic signed [acc_w(DATA_W)-1:0] sum
);
    localparam int SUM_W = acc_w(DATA_W);

    logic signed [SUM_W-1:0] p0;
    logic signed [SUM_W-1:0] p1;

    always_comb begin
        p0  = x0 * w0;
        p1  = x1 * w1;
        sum = p0 + p1;
    end

endmodule

// File: rtl/neuron_layer_sequencer.sv
// Layer controller: buffers one input vector, then runs each neuron through a shared
// 2-term MAC, applies a step activation and streams one result per neuron.
module neuron_layer_sequencer
    import neuron_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int N_INPUTS  = 8,
    parameter int N_NEURONS = 4
) (
    input  logic   clock,
    input  logic   reset,
    neuron_layer_sequencer_if.slave bus,
    output state_t dbg_state
);
    localparam int N_W     = N_INPUTS * N_NEURONS;
    localparam int N_PAIRS = N_INPUTS / 2;
    localparam int WA_W    = $clog2(N_W);
    localparam int IDX_W   = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam int EL_W    = $clog2(N_INPUTS);
    localparam int PR_W    = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
    localparam int SUM_W   = acc_w(DATA_W);

    state_t                   state;
    logic [EL_W-1:0]          elem_cnt;
    logic [PR_W-1:0]          pair_cnt;
    logic [IDX_W-1:0]         nrn;
    logic signed [DATA_W-1:0] x_buf   [N_INPUTS];
    logic signed [DATA_W-1:0] weights [N_W];
    logic signed [SUM_W-1:0]  acc;
    logic                     in_ready_r;
    logic                     out_valid_r;
    logic                     busy_r;
    logic [DATA_W-1:0]        out_data_r;
    logic [IDX_W-1:0]         out_idx_r;

    logic [EL_W-1:0]          x_lo;
    logic [EL_W-1:0]          x_hi;
    logic [WA_W-1:0]          w_lo;
    logic [WA_W-1:0]          w_hi;
    logic signed [SUM_W-1:0]  pair_sum;
    logic signed [SUM_W-1:0]  acc_next;
    logic                     wr_hit;
    logic                     in_hs;
    logic                     out_hs;
    logic                     last_elem;
    logic                     last_pair;
    logic                     last_nrn;

    // Operand addresses for the current pair of the current neuron.
    always_comb begin
        x_lo      = EL_W'(2 * int'(pair_cnt));
        x_hi      = EL_W'(2 * int'(pair_cnt) + 1);
        w_lo      = WA_W'(int'(nrn) * N_INPUTS + 2 * int'(pair_cnt));
        w_hi      = WA_W'(int'(nrn) * N_INPUTS + 2 * int'(pair_cnt) + 1);
        acc_next  = acc + pair_sum;
        wr_hit    = bus.io_wr_en && (state == LOAD) && (int'(bus.io_wr_addr) < N_W);
        in_hs     = bus.io_in_valid && in_ready_r;
        out_hs    = out_valid_r && bus.io_out_ready;
        last_elem = (elem_cnt == EL_W'(N_INPUTS - 1));
        last_pair = (pair_cnt == PR_W'(N_PAIRS - 1));
        last_nrn  = (nrn == IDX_W'(N_NEURONS - 1));
    end

    neuron_mac2 #(.DATA_W(DATA_W)) u_mac2 (
        .x0  (x_buf[x_lo]),
        .w0  (weights[w_lo]),
        .x1  (x_buf[x_hi]),
        .w1  (weights[w_hi]),
        .sum (pair_sum)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= LOAD;
            elem_cnt    <= '0;
            pair_cnt    <= '0;
            nrn         <= '0;
            acc         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            out_data_r  <= '0;
            out_idx_r   <= '0;
            for (int i = 0; i < N_INPUTS; i++) x_buf[i] <= '0;
            for (int i = 0; i < N_W; i++) weights[i] <= '0;
        end else begin
            if (wr_hit) weights[bus.io_wr_addr] <= bus.io_wr_data;
            case (state)
                LOAD: begin
                    if (in_hs) begin
                        x_buf[elem_cnt] <= bus.io_in_data;
                        elem_cnt        <= elem_cnt + EL_W'(1);
                        if (last_elem) begin
                            state      <= MAC;
                            acc        <= '0;
                            pair_cnt   <= '0;
                            nrn        <= '0;
                            in_ready_r <= 1'b0;
                            busy_r     <= 1'b1;
                        end
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    if (last_pair) begin
                        // Non-positive sums (including wrapped-negative ones) fire zero.
                        out_data_r  <= (acc_next <= 0) ? DATA_W'(ACT_ZERO) : DATA_W'(ACT_ONE);
                        out_idx_r   <= nrn;
                        out_valid_r <= 1'b1;
                        state       <= EMIT;
                    end else begin
                        pair_cnt <= pair_cnt + PR_W'(1);
                    end
                end
                EMIT: begin
                    if (out_hs) begin
                        out_valid_r <= 1'b0;
                        if (last_nrn) begin
                            state      <= LOAD;
                            elem_cnt   <= '0;
                            in_ready_r <= 1'b1;
                            busy_r     <= 1'b0;
                        end else begin
                            state    <= MAC;
                            nrn      <= nrn + IDX_W'(1);
                            acc      <= '0;
                            pair_cnt <= '0;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    assign bus.io_in_ready  = in_ready_r;
    assign bus.io_out_valid = out_valid_r;
    assign bus.io_out_data  = out_data_r;
    assign bus.io_out_idx   = out_idx_r;
    assign bus.io_busy      = busy_r;
    assign dbg_state        = state;

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Directed scoreboard bench for neuron_layer_sequencer with 4 inputs x 3 neurons.
module tb_neuron_layer_sequencer;
    import neuron_pkg::*;

    localparam int DW = 16;
    localparam int NI = 4;
    localparam int NN = 3;
    localparam int AW = 4;
    localparam int IW = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    state_t      dbg_state;
    int unsigned cycle = 0;

    neuron_layer_sequencer_if #(.DATA_W(DW), .N_INPUTS(NI), .N_NEURONS(NN)) bus ();

    neuron_layer_sequencer #(.DATA_W(DW), .N_INPUTS(NI), .N_NEURONS(NN)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock and cycle count
    always #5 clock = ~clock;
    always @(posedge clock) cycle <= cycle + 1;

    // Scoreboard
    logic [IW+DW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cycle);
    endtask

    // Monitor: pops the expected queue on every output handshake and checks latency
    int          in_hs_cnt  = 0;
    int unsigned last_hs    = 0;
    logic        prev_valid = 1'b0;

    always @(negedge clock) begin
        logic [IW+DW-1:0] e;
        if (reset) begin
            in_hs_cnt  = 0;
            prev_valid = 1'b0;
        end else begin
            if (bus.io_out_valid && !prev_valid)
                check("latency", cycle - last_hs, NI / 2 + 1);
            prev_valid = bus.io_out_valid;
            if (bus.io_in_valid && bus.io_in_ready) begin
                if (in_hs_cnt == NI - 1) begin
                    in_hs_cnt = 0;
                    last_hs   = cycle;
                end else begin
                    in_hs_cnt++;
                end
            end
            if (bus.io_out_valid && bus.io_out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got idx %0d data 0x%0h, expected no result",
                             bus.io_out_idx, bus.io_out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", bus.io_out_data, e[DW-1:0]);
                    check("out_idx", bus.io_out_idx, e[IW+DW-1:DW]);
                end
                last_hs = cycle;
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_w(input int addr, input int val);
        bus.io_wr_en   = 1'b1;
        bus.io_wr_addr = AW'(addr);
        bus.io_wr_data = DW'(val);
        tick();
        bus.io_wr_en   = 1'b0;
    endtask

    task automatic set_neuron(input int n, input int a, input int b, input int c, input int d);
        write_w(n * NI + 0, a);
        write_w(n * NI + 1, b);
        write_w(n * NI + 2, c);
        write_w(n * NI + 3, d);
    endtask

    task automatic load4(input int a, input int b, input int c, input int d);
        int v[4];
        int budget;
        v = '{a, b, c, d};
        for (int i = 0; i < NI; i++) begin
            bus.io_in_valid = 1'b1;
            bus.io_in_data  = DW'(v[i]);
            budget = 0;
            while (!bus.io_in_ready && budget < 50) begin
                tick();
                budget++;
            end
            if (budget >= 50) fail_now("in_ready_wait");
            tick();
        end
        bus.io_in_valid = 1'b0;
    endtask

    task automatic expect_res(input int idx, input int data);
        exp_q.push_back({IW'(idx), DW'(data)});
    endtask

    task automatic drain();
        int budget = 0;
        while (exp_q.size() != 0 && budget < 100) begin
            tick();
            budget++;
        end
        if (budget >= 100) fail_now("drain");
    endtask

    // Stimulus
    initial begin
        bus.io_wr_en     = 1'b0;
        bus.io_wr_addr   = '0;
        bus.io_wr_data   = '0;
        bus.io_in_valid  = 1'b0;
        bus.io_in_data   = '0;
        bus.io_out_ready = 1'b1;
        repeat (3) tick();
        check("rst_in_ready", bus.io_in_ready, 1);
        check("rst_out_valid", bus.io_out_valid, 0);
        check("rst_out_data", bus.io_out_data, 0);
        check("rst_out_idx", bus.io_out_idx, 0);
        check("rst_busy", bus.io_busy, 0);
        check("rst_state", dbg_state, LOAD);
        reset = 1'b0;
        tick();

        // Basic layer: sums 10, -10, 4
        set_neuron(0, 1, 1, 1, 1);
        set_neuron(1, -1, -1, -1, -1);
        set_neuron(2, 2, -1, 0, 1);
        expect_res(0, 'h0100);
        expect_res(1, 'h0000);
        expect_res(2, 'h0100);
        load4(1, 2, 3, 4);
        check("t1_state_mac", dbg_state, MAC);
        check("t1_in_ready_mac", bus.io_in_ready, 0);
        check("t1_busy_mac", bus.io_busy, 1);
        drain();
        check("t1_in_ready_after", bus.io_in_ready, 1);
        check("t1_busy_after", bus.io_busy, 0);

        // Zero boundary: sums 0, -20, 10 then 1, -19, 9
        set_neuron(0, 1, -1, 1, -1);
        expect_res(0, 'h0000);
        expect_res(1, 'h0000);
        expect_res(2, 'h0100);
        load4(5, 5, 5, 5);
        drain();
        expect_res(0, 'h0100);
        expect_res(1, 'h0000);
        expect_res(2, 'h0100);
        load4(5, 5, 5, 4);
        drain();

        // Backpressure with stray input valid held during EMIT
        bus.io_out_ready = 1'b0;
        expect_res(0, 'h0100);
        expect_res(1, 'h0000);
        expect_res(2, 'h0100);
        load4(5, 5, 5, 4);
        begin
            int budget = 0;
            while (!bus.io_out_valid && budget < 20) begin
                tick();
                budget++;
            end
            if (budget >= 20) fail_now("t3_valid_wait");
        end
        bus.io_in_valid = 1'b1;
        bus.io_in_data  = DW'(-100);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_hold_valid", bus.io_out_valid, 1);
            check("t3_hold_data", bus.io_out_data, 'h0100);
            check("t3_hold_idx", bus.io_out_idx, 0);
            check("t3_hold_in_ready", bus.io_in_ready, 0);
            check("t3_hold_busy", bus.io_busy, 1);
        end
        bus.io_in_valid  = 1'b0;
        bus.io_out_ready = 1'b1;
        drain();

        // Wrap: 4 * 0x3FFF0001 = 0xFFFC0004, negative
        for (int a = 0; a < NI * NN; a++) write_w(a, 'h7FFF);
        expect_res(0, 'h0000);
        expect_res(1, 'h0000);
        expect_res(2, 'h0000);
        load4('h7FFF, 'h7FFF, 'h7FFF, 'h7FFF);
        drain();

        // Ignored writes: one during MAC, two out of range in LOAD
        set_neuron(0, 1, 1, 1, 1);
        set_neuron(1, -1, -1, -1, -1);
        set_neuron(2, 1, 1, 1, 1);
        expect_res(0, 'h0100);
        expect_res(1, 'h0000);
        expect_res(2, 'h0100);
        load4(1, 2, 3, 4);
        check("t6_state_mac", dbg_state, MAC);
        write_w(4, 'h7FFF);
        drain();
        write_w(12, 'h7FFF);
        write_w(15, 'h7FFF);
        expect_res(0, 'h0100);
        expect_res(1, 'h0000);
        expect_res(2, 'h0100);
        load4(1, 2, 3, 4);
        drain();

        // Reset mid-MAC aborts; weights are cleared so everything fires zero
        load4(1, 2, 3, 4);
        check("t5_state_mac", dbg_state, MAC);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_in_ready", bus.io_in_ready, 1);
        check("t5_out_valid", bus.io_out_valid, 0);
        check("t5_busy", bus.io_busy, 0);
        check("t5_state", dbg_state, LOAD);
        repeat (4) tick();
        check("t5_no_partial", bus.io_out_valid, 0);
        expect_res(0, 'h0000);
        expect_res(1, 'h0000);
        expect_res(2, 'h0000);
        load4(1, 2, 3, 4);
        drain();

        repeat (2) tick();
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
